// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single data memory between the pipeline MEM
// stage (P) and a debug/loader port (D). P has priority; D uses free cycles,
// or steals one cycle by stalling P once it has been denied MAX_WAIT cycles.
// A granted D read returns its data the following cycle (DRD state).
module data_mem_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pipe_mem_read,
  input  logic              pipe_mem_write,
  input  logic [ADDR_W-1:0] pipe_address,
  input  logic [31:0]       pipe_wdata,
  output logic              pipe_stall,
  output logic [31:0]       pipe_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_address,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_rvalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic {IDLE = 1'b0, DRD = 1'b1} state_t;

  state_t           state_p1;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      rdata_p1;
  logic             pacc;
  logic             force_gnt;
  logic             dbg_rd_gnt;
  logic             vld_p1;

  // Saturating increment of the D starvation counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == WAIT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Grant decision: D wins only when P is idle or D has starved long enough.
  always_comb begin
    pacc       = pipe_mem_read | pipe_mem_write;
    force_gnt  = dbg_req & (wait_cnt == WAIT_MAX);
    dbg_gnt    = reset_n & dbg_req & (~pacc | force_gnt);
    pipe_stall = dbg_gnt & pacc;
    dbg_rd_gnt = dbg_gnt & ~dbg_we;
  end

  // Memory pin mux; no access strobes leave the block while in reset.
  always_comb begin
    if (dbg_gnt) begin
      mem_address = dbg_address;
      mem_wdata   = dbg_wdata;
      mem_write   = dbg_we;
      mem_read    = ~dbg_we;
    end else begin
      mem_address = pipe_address;
      mem_wdata   = pipe_wdata;
      mem_write   = reset_n & pipe_mem_write;
      mem_read    = reset_n & pipe_mem_read;
    end
  end

  // Count consecutive denied D-request cycles; any grant or idle D clears it.
  always_ff @(posedge clock) begin
    if (!reset_n)
      wait_cnt <= '0;
    else if (dbg_gnt || !dbg_req)
      wait_cnt <= '0;
    else
      wait_cnt <= sat_inc(wait_cnt);
  end

  // ---- stage p0 -> p1: D read issued, data returns next cycle ----

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n)
      state_p1 <= IDLE;
    else
      state_p1 <= state_nxt;
  end

  // FSM next state: any granted D read (including back-to-back) lands in DRD.
  always_comb begin
    state_nxt = IDLE;
    case (state_p1)
      IDLE:    state_nxt = dbg_rd_gnt ? DRD : IDLE;
      DRD:     state_nxt = dbg_rd_gnt ? DRD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: in DRD the memory output is the D read data; a reset
  // arriving during DRD drops the return.
  always_comb begin
    vld_p1     = reset_n & (state_p1 == DRD);
    dbg_rvalid = vld_p1;
    dbg_rdata  = vld_p1 ? mem_rdata : rdata_p1;
  end

  // Hold the most recent D read data after its valid pulse.
  always_ff @(posedge clock) begin
    if (!reset_n)
      rdata_p1 <= '0;
    else if (vld_p1)
      rdata_p1 <= mem_rdata;
  end

  assign pipe_rdata = mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed scenarios plus randomized traffic, checked
// against a cycle-level reference model built from the arbitration rules
// (starvation counter as an int, shadow memory for expected read data).
module tb_data_mem_arbiter;

  localparam int ADDR_W   = 11;
  localparam int MAX_WAIT = 8;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              pipe_mem_read, pipe_mem_write;
  logic [ADDR_W-1:0] pipe_address;
  logic [31:0]       pipe_wdata;
  logic              pipe_stall;
  logic [31:0]       pipe_rdata;
  logic              dbg_req, dbg_we;
  logic [ADDR_W-1:0] dbg_address;
  logic [31:0]       dbg_wdata;
  logic              dbg_gnt;
  logic [31:0]       dbg_rdata;
  logic              dbg_rvalid;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_wdata;
  logic              mem_write, mem_read;
  logic [31:0]       mem_rdata = '0;

  data_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset_n(reset_n),
    .pipe_mem_read(pipe_mem_read), .pipe_mem_write(pipe_mem_write),
    .pipe_address(pipe_address), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall), .pipe_rdata(pipe_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_address(dbg_address),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .dbg_rvalid(dbg_rvalid), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous data memory: read data appears the cycle after mem_read.
  logic [31:0] mem_arr [2048];
  always @(posedge clock) begin
    if (mem_write) mem_arr[mem_address] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem_arr[mem_address];
  end

  int vectors = 0;
  int errors  = 0;

  // Reference model state.
  int          m_wait = 0;
  bit          m_rv = 0, m_pv = 0;
  logic [31:0] m_rd = '0, m_last = '0, m_pd = '0;
  logic [31:0] shadow [2048];

  // Per-cycle expectations.
  bit              e_gnt, e_stall, e_mr, e_mw, e_rv, e_rd_chk, e_pv;
  logic [ADDR_W-1:0] e_ma;
  logic [31:0]     e_mwd, e_rd, e_pd;

  task automatic drive(input bit rn, input bit pr, input bit pw,
                       input logic [ADDR_W-1:0] pa, input logic [31:0] pwd,
                       input bit dr, input bit dw,
                       input logic [ADDR_W-1:0] da, input logic [31:0] dwd);
    reset_n = rn; pipe_mem_read = pr; pipe_mem_write = pw;
    pipe_address = pa; pipe_wdata = pwd;
    dbg_req = dr; dbg_we = dw; dbg_address = da; dbg_wdata = dwd;
  endtask

  // Settle, then derive this cycle's expected outputs from the model.
  task automatic eval();
    bit pacc, frc;
    #1;
    pacc    = pipe_mem_read | pipe_mem_write;
    frc     = dbg_req && (m_wait == MAX_WAIT);
    e_gnt   = reset_n && dbg_req && (!pacc || frc);
    e_stall = e_gnt && pacc;
    e_ma    = e_gnt ? dbg_address : pipe_address;
    e_mwd   = e_gnt ? dbg_wdata : pipe_wdata;
    e_mw    = reset_n && (e_gnt ? dbg_we : pipe_mem_write);
    e_mr    = reset_n && (e_gnt ? !dbg_we : pipe_mem_read);
    e_rv    = reset_n && m_rv;
    e_rd    = e_rv ? m_rd : m_last;
    e_rd_chk = reset_n;
    e_pv    = reset_n && m_pv;
    e_pd    = m_pd;
  endtask

  // Advance the model across the coming clock edge, then wait for the next cycle.
  task automatic commit();
    bit rd_now;
    rd_now = e_gnt && !dbg_we;
    if (!reset_n) begin
      m_wait = 0; m_rv = 0; m_last = '0; m_pv = 0;
    end else begin
      if (m_rv) m_last = m_rd;
      m_pv = !e_gnt && pipe_mem_read;
      if (m_pv) m_pd = shadow[pipe_address];
      m_rv = rd_now;
      if (rd_now) m_rd = shadow[dbg_address];
      if (e_gnt || !dbg_req) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      if (e_gnt && dbg_we) shadow[dbg_address] = dbg_wdata;
      else if (!e_gnt && pipe_mem_write) shadow[pipe_address] = pipe_wdata;
    end
    @(negedge clock);
  endtask

  task automatic idle_cycle();
    drive(1, 0, 0, '0, '0, 0, 0, '0, '0);
    eval();
    commit();
  endtask

  task automatic test_reset();
    drive(0, 1, 0, 11'h003, 32'h0, 1, 1, 11'h005, 32'h1234);
    repeat (2) begin
      eval();
      vectors++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", dbg_gnt); end
      vectors++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
      vectors++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
      vectors++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", pipe_stall); end
      vectors++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", dbg_rvalid); end
      commit();
    end
    drive(1, 0, 0, '0, '0, 0, 0, '0, '0);
    eval();
    vectors++; if (dbg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", dbg_rdata); end
    vectors++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid_after: got %b want 0", dbg_rvalid); end
    commit();
  endtask

  task automatic test_dbg_write_read();
    drive(1, 0, 0, '0, '0, 1, 1, 11'h010, 32'hDEADBEEF);
    eval();
    vectors++; if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", dbg_gnt); end
    vectors++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL wr_stall: got %b want 0", pipe_stall); end
    vectors++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL wr_strobes: got w%b r%b want w1 r0", mem_write, mem_read); end
    vectors++; if (mem_address !== 11'h010 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_bus: got %h/%h want 010/deadbeef", mem_address, mem_wdata); end
    commit();
    drive(1, 0, 0, '0, '0, 1, 0, 11'h010, '0);
    eval();
    vectors++; if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", dbg_gnt); end
    vectors++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL rd_strobes: got w%b r%b want w0 r1", mem_write, mem_read); end
    vectors++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid: got %b want 0", dbg_rvalid); end
    commit();
    drive(1, 0, 0, '0, '0, 0, 0, '0, '0);
    eval();
    vectors++; if (dbg_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b want 1", dbg_rvalid); end
    vectors++; if (dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", dbg_rdata); end
    commit();
    drive(1, 0, 0, '0, '0, 0, 0, '0, '0);
    eval();
    vectors++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse: got %b want 0", dbg_rvalid); end
    vectors++; if (dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold: got %h want deadbeef", dbg_rdata); end
    commit();
  endtask

  task automatic test_forced_grant();
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 0, 11'($urandom_range(0, 15)), '0, 1, 0, 11'h010, '0);
      eval();
      vectors++; if (dbg_gnt !== 1'((k == 8) || (k == 17))) begin errors++; $display("FAIL force_gnt[%0d]: got %b want %b", k, dbg_gnt, (k == 8) || (k == 17)); end
      vectors++; if (pipe_stall !== 1'((k == 8) || (k == 17))) begin errors++; $display("FAIL force_stall[%0d]: got %b want %b", k, pipe_stall, (k == 8) || (k == 17)); end
      if (k == 9 || k == 18) begin
        vectors++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL force_rdata[%0d]: got v%b %h want v1 deadbeef", k, dbg_rvalid, dbg_rdata); end
      end else if (e_pv) begin
        vectors++; if (pipe_rdata !== e_pd) begin errors++; $display("FAIL force_prdata[%0d]: got %h want %h", k, pipe_rdata, e_pd); end
      end
      commit();
    end
    idle_cycle();
  endtask

  task automatic test_p_wins();
    drive(1, 0, 1, 11'h004, 32'h00000055, 1, 0, 11'h004, '0);
    eval();
    vectors++; if (dbg_gnt !== 1'b0 || pipe_stall !== 1'b0) begin errors++; $display("FAIL pwin_gnt: got g%b s%b want g0 s0", dbg_gnt, pipe_stall); end
    vectors++; if (mem_write !== 1'b1 || mem_address !== 11'h004 || mem_wdata !== 32'h55) begin errors++; $display("FAIL pwin_bus: got w%b %h/%h want w1 004/00000055", mem_write, mem_address, mem_wdata); end
    commit();
    drive(1, 0, 0, '0, '0, 1, 0, 11'h004, '0);
    eval();
    vectors++; if (dbg_gnt !== 1'b1 || mem_read !== 1'b1) begin errors++; $display("FAIL pwin_dgnt: got g%b r%b want g1 r1", dbg_gnt, mem_read); end
    commit();
    drive(1, 0, 0, '0, '0, 0, 0, '0, '0);
    eval();
    vectors++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h00000055) begin errors++; $display("FAIL pwin_rdata: got v%b %h want v1 00000055", dbg_rvalid, dbg_rdata); end
    commit();
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, '0, '0, 1, 1, 11'h001, 32'h11);
    eval(); commit();
    drive(1, 0, 0, '0, '0, 1, 1, 11'h002, 32'h22);
    eval(); commit();
    drive(1, 0, 0, '0, '0, 1, 0, 11'h001, '0);
    eval();
    vectors++; if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt1: got %b want 1", dbg_gnt); end
    commit();
    drive(1, 0, 0, '0, '0, 1, 0, 11'h002, '0);
    eval();
    vectors++; if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt2: got %b want 1", dbg_gnt); end
    vectors++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h11) begin errors++; $display("FAIL b2b_first: got v%b %h want v1 00000011", dbg_rvalid, dbg_rdata); end
    commit();
    drive(1, 0, 0, '0, '0, 0, 0, '0, '0);
    eval();
    vectors++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h22) begin errors++; $display("FAIL b2b_second: got v%b %h want v1 00000022", dbg_rvalid, dbg_rdata); end
    commit();
    drive(1, 0, 0, '0, '0, 0, 0, '0, '0);
    eval();
    vectors++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", dbg_rvalid); end
    commit();
  endtask

  task automatic test_reset_mid_read();
    drive(1, 0, 0, '0, '0, 1, 0, 11'h010, '0);
    eval();
    vectors++; if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL rst_mid_gnt: got %b want 1", dbg_gnt); end
    commit();
    drive(0, 0, 0, '0, '0, 1, 1, 11'h020, 32'hCAFE0001);
    eval();
    vectors++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_rvalid: got %b want 0", dbg_rvalid); end
    vectors++; if (dbg_gnt !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL rst_mid_gnt_wr: got g%b w%b want g0 w0", dbg_gnt, mem_write); end
    commit();
    drive(1, 0, 0, '0, '0, 1, 1, 11'h020, 32'hCAFE0001);
    eval();
    vectors++; if (dbg_gnt !== 1'b1 || mem_write !== 1'b1) begin errors++; $display("FAIL rst_rel_gnt: got g%b w%b want g1 w1", dbg_gnt, mem_write); end
    vectors++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0) begin errors++; $display("FAIL rst_rel_drop: got v%b %h want v0 0", dbg_rvalid, dbg_rdata); end
    commit();
    idle_cycle();
  endtask

  task automatic test_req_drop();
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 0, 11'($urandom_range(0, 15)), '0, (k < 5), 0, 11'h004, '0);
      eval();
      vectors++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL drop_pre[%0d]: got %b want 0", k, dbg_gnt); end
      commit();
    end
    for (int j = 0; j < 10; j++) begin
      drive(1, 1, 0, 11'($urandom_range(0, 15)), '0, 1, 0, 11'h004, '0);
      eval();
      vectors++; if (dbg_gnt !== 1'(j == 8) || pipe_stall !== 1'(j == 8)) begin errors++; $display("FAIL drop_post[%0d]: got g%b s%b want %b", j, dbg_gnt, pipe_stall, j == 8); end
      commit();
    end
    idle_cycle();
  endtask

  task automatic test_random();
    bit dp = 0, dw = 0;
    logic [ADDR_W-1:0] da = '0;
    logic [31:0] dwd = '0;
    int r;
    for (int c = 0; c < 400; c++) begin
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; dw = 1'($urandom_range(0, 1));
        da = 11'($urandom_range(0, 15)); dwd = $urandom;
      end
      r = $urandom_range(0, 9);
      drive(($urandom_range(0, 49) != 0), (r < 4), (r >= 4 && r < 6),
            11'($urandom_range(0, 15)), $urandom, dp, dw, da, dwd);
      eval();
      vectors++; if (dbg_gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b want %b", c, dbg_gnt, e_gnt); end
      vectors++; if (pipe_stall !== e_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", c, pipe_stall, e_stall); end
      vectors++; if (mem_read !== e_mr || mem_write !== e_mw) begin errors++; $display("FAIL rnd_strobes[%0d]: got r%b w%b want r%b w%b", c, mem_read, mem_write, e_mr, e_mw); end
      vectors++; if (mem_address !== e_ma || mem_wdata !== e_mwd) begin errors++; $display("FAIL rnd_bus[%0d]: got %h/%h want %h/%h", c, mem_address, mem_wdata, e_ma, e_mwd); end
      vectors++; if (dbg_rvalid !== e_rv) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", c, dbg_rvalid, e_rv); end
      if (e_rd_chk) begin
        vectors++; if (dbg_rdata !== e_rd) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, dbg_rdata, e_rd); end
      end
      if (e_rv) begin
        vectors++; if (pipe_rdata !== e_rd) begin errors++; $display("FAIL rnd_prdata_d[%0d]: got %h want %h", c, pipe_rdata, e_rd); end
      end else if (e_pv) begin
        vectors++; if (pipe_rdata !== e_pd) begin errors++; $display("FAIL rnd_prdata[%0d]: got %h want %h", c, pipe_rdata, e_pd); end
      end
      if (dbg_gnt) dp = 0;
      commit();
    end
    idle_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem_arr[i] = '0;
      shadow[i]  = '0;
    end
    drive(0, 0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge clock);
    test_reset();
    test_dbg_write_read();
    test_forced_grant();
    test_p_wins();
    test_back_to_back();
    test_reset_mid_read();
    test_req_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data memory between two requesters: the pipeline MEM stage (port P) and a debug/loader port (port D).
- The pipeline has priority. D is served in free cycles, or by forcing a one-cycle pipeline stall once D has waited MAX_WAIT cycles.
- Sits between the memory-access stage and data_mem. It drives every data_mem control and address pin.

Parameters:
- ADDR_W, 11, word address width presented to data_mem.
- MAX_WAIT, 8, number of consecutive denied D-request cycles before D is forced through (1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- pipe_mem_read  in  1  P read request (MemRead).
- pipe_mem_write  in  1  P write request (MemWrite).
- pipe_address  in  ADDR_W  P address.
- pipe_wdata  in  32  P write data.
- pipe_stall  out  1  P must hold its request and stage registers this cycle.
- pipe_rdata  out  32  read data to the MEM/WB register.
- dbg_req  in  1  D request, held until granted.
- dbg_we  in  1  D access is a write (1) or a read (0).
- dbg_address  in  ADDR_W  D address.
- dbg_wdata  in  32  D write data.
- dbg_gnt  out  1  D access is issued to memory this cycle.
- dbg_rdata  out  32  D read data, registered.
- dbg_rvalid  out  1  one-cycle pulse, dbg_rdata valid.
- mem_address  out  ADDR_W  to data_mem.
- mem_wdata  out  32  to data_mem.
- mem_write  out  1  to data_mem.
- mem_read  out  1  to data_mem.
- mem_rdata  in  32  from data_mem; valid the cycle after mem_read.

Behaviour:
- Definitions:
  - pacc = pipe_mem_read | pipe_mem_write.
  - force = dbg_req & (wait_cnt == MAX_WAIT).
- Grant (combinational):
  - dbg_gnt = reset_n & dbg_req & (~pacc | force).
  - pipe_stall = dbg_gnt & pacc.
- Memory mux:
  - If dbg_gnt: mem_address = dbg_address, mem_wdata = dbg_wdata, mem_write = dbg_we, mem_read = ~dbg_we.
  - Else: drive the P signals straight through.
  - While reset_n = 0, mem_write and mem_read are forced to 0.
- Handshake: D holds req, we, address and wdata stable until it samples dbg_gnt = 1. The request is consumed at that edge. A D write completes in the grant cycle.
- wait_cnt (register, width ceil(log2(MAX_WAIT+1))):
  - Cleared on dbg_gnt or when dbg_req = 0.
  - Otherwise increments each cycle, saturating at MAX_WAIT.
- FSM states: IDLE, DRD (D read returning).
  - IDLE to DRD: dbg_gnt & ~dbg_we.
  - DRD: dbg_rvalid = 1 and dbg_rdata <= mem_rdata, registered at the edge closing the grant cycle.
  - DRD to DRD: another D read is granted this cycle (back-to-back reads allowed).
  - DRD to IDLE: otherwise.
  - Memory is free for P or D in DRD. A new grant in DRD does not corrupt the returning data, because data lags its address by one cycle.
- pipe_rdata = mem_rdata, unconditionally.
  - The cycle after a D read, mem_rdata carries D data; P did not issue a read then, so MemToReg is not used.
  - A stalled P re-issues its access the next cycle.
- Simultaneous events:
  - P access with D below threshold: P wins, no stall.
  - P and D both idle: no memory access.
  - D forced: P stalled exactly one cycle. wait_cnt then clears, so P runs unstalled for at least MAX_WAIT cycles while D waits.
- Reset values: state IDLE, wait_cnt 0, dbg_rvalid 0, dbg_rdata 0. A pending DRD return is dropped if reset hits mid-read.

Test Plan:
- P idle, D write 0xDEADBEEF to 0x010, then D read 0x010 → dbg_gnt = 1 on the first cycle each time, no pipe_stall; dbg_rvalid pulses one cycle after the read grant with dbg_rdata = 0xDEADBEEF.
- P issues a read every cycle, D requests continuously, MAX_WAIT = 8 → D is denied 8 cycles, granted on the 9th with pipe_stall = 1 that cycle only; the next grant comes 9 cycles later.
- P write 0x00000055 to 0x004 in the same cycle as D read 0x004 below threshold → P wins; D is granted next free cycle and reads 0x00000055.
- Back-to-back D reads of 0x001 and 0x002 (values 0x11, 0x22) in consecutive free cycles → dbg_rvalid high two consecutive cycles, dbg_rdata 0x11 then 0x22.
- reset_n low during a DRD cycle with dbg_req = 1 → dbg_rvalid = 0, dbg_gnt = 0, mem_write = 0, wait_cnt = 0; after release, D is granted on the first free cycle.
- dbg_req dropped at wait_cnt = 5 and re-asserted → counting restarts at 0; forced grant only after 8 further denied cycles.
